// File: rtl/acc_store_unit_pkg.sv
// rtl/acc_store_unit_pkg.sv - shared store-unit state encodings and defaults
package acc_store_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } st_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int WAIT_W          = 8;

endpackage

// File: rtl/acc_store_unit_if.sv
// rtl/acc_store_unit_if.sv - data memory write bus between store unit and responder
interface acc_store_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              memAck;

  modport master (output memReq, output memAddr, output memData, input memAck);
  modport slave  (input memReq, input memAddr, input memData, output memAck);
endinterface

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - 2-entry FIFO of packed {addr, data} store entries
module store_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // A full FIFO refuses the push even if the head is popped in the same cycle.
  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/acc_store_unit.sv
// rtl/acc_store_unit.sv - buffers accumulator stores and drains them to the memory bus
// with a per-entry ack timeout and a sticky error flag.
module acc_store_unit
  import acc_store_unit_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] accOut,
  input  logic              stEn,
  input  logic              stNeg,
  input  logic [ADDR_W-1:0] stAddr,
  output logic              stBusy,
  acc_store_unit_if.master  mem,
  output logic              stErr,
  input  logic              stErrClr
);

  localparam int EW = ADDR_W + DATA_W;

  st_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stErr_q, stErr_d;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_dout;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              acked;
  logic              timeout_hit;
  logic              in_req;

  assign in_req      = (state_q == ST_REQ);
  assign push        = stEn && (count != 2'd2);
  assign acked       = in_req && mem.memAck;
  assign timeout_hit = in_req && !mem.memAck && (wait_q == WAIT_W'(TIMEOUT - 1));
  assign pop         = acked || timeout_hit;
  assign fifo_din    = {stAddr, (stNeg ? ~accOut : accOut)};

  store_fifo #(.W(EW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stErr_d = stErr_q;
    // Set wins over a simultaneous clear so a timeout is never lost.
    if (timeout_hit) begin
      stErr_d = 1'b1;
    end else if (stErrClr) begin
      stErr_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (count != 2'd0) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (pop) begin
          wait_d = '0;
          if ((count == 2'd1) && !push) begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      stErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stErr_q <= stErr_d;
    end
  end

  assign stBusy      = (count == 2'd2);
  assign stErr       = stErr_q;
  assign mem.memReq  = in_req;
  assign mem.memAddr = in_req ? fifo_dout[EW-1:DATA_W] : '0;
  assign mem.memData = in_req ? fifo_dout[DATA_W-1:0] : '0;

endmodule
